// File: rtl/params_pkg.sv
// params_pkg: shared widths, access-size encoding and load/store unit types.
// Holds the lsu FSM state, the latched request bundle and lane helpers.
package params_pkg;

  localparam int ADDR_WIDTH     = 32;
  localparam int DATA_WIDTH     = 32;
  localparam int REGISTER_WIDTH = 5;

  // 2'b11 is not a member; it is still carried on the wire
  // and handled as WORD or as a misaligned access.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } access_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RESP  = 2'b10
  } lsu_state_t;

  typedef struct packed {
    logic                      is_store;
    access_size_t              size;
    logic                      is_unsigned;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [REGISTER_WIDTH-1:0] rd;
  } lsu_req_t;

  function automatic logic [3:0] byte_enable(
    input access_size_t size,
    input logic [1:0]   off
  );
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic misaligned(
    input access_size_t size,
    input logic [1:0]   off
  );
    logic m;
    case (size)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = off[0];
      SZ_WORD: m = (off != 2'b00);
      default: m = 1'b1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// lsu_load_align: picks the addressed lane of a read word and extends it.
// Ports: rdata (word), size, is_unsigned, off (addr[1:0]) -> data.
module lsu_load_align
  import params_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] rdata,
  input  access_size_t          size,
  input  logic                  is_unsigned,
  input  logic [1:0]            off,
  output logic [DATA_WIDTH-1:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[7:0];
    unique case (off)
      2'd0: b = rdata[7:0];
      2'd1: b = rdata[15:8];
      2'd2: b = rdata[23:16];
      2'd3: b = rdata[31:24];
      default: b = rdata[7:0];
    endcase
  end

  // Odd half offsets fold down to the aligned half.
  assign h = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    case (size)
      SZ_BYTE: data = {{24{~is_unsigned & b[7]}}, b};
      SZ_HALF: data = {{16{~is_unsigned & h[15]}}, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store stage, one request at a time over a word port.
// req_* in (valid/ready), mem_* word port with byte enables, resp_* out.
// Option MISALIGN_TRAP_EN: misaligned requests fault without memory access.
module mem_access_unit
  import params_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_is_store,
  input  access_size_t              req_size,
  input  logic                      req_unsigned,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [REGISTER_WIDTH-1:0] req_rd,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [3:0]                mem_be,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic                      mem_ack,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [DATA_WIDTH-1:0]     resp_rdata,
  output logic [REGISTER_WIDTH-1:0] resp_rd,
  output logic                      resp_fault
);

  lsu_state_t            state;
  lsu_req_t              r;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] rep_wdata;

  lsu_load_align u_align (
    .rdata       (mem_rdata),
    .size        (r.size),
    .is_unsigned (r.is_unsigned),
    .off         (r.addr[1:0]),
    .data        (load_data)
  );

  always_comb begin
    rep_wdata = r.wdata;
    case (r.size)
      SZ_BYTE: rep_wdata = {4{r.wdata[7:0]}};
      SZ_HALF: rep_wdata = {2{r.wdata[15:0]}};
      default: rep_wdata = r.wdata;
    endcase
  end

  // The memory side is a pure function of the latched request,
  // so it cannot move while mem_req is waiting for mem_ack.
  assign req_ready = (state == IDLE);
  assign mem_we    = mem_req & r.is_store;
  assign mem_addr  = {r.addr[ADDR_WIDTH-1:2], 2'b00};
  assign mem_be    = mem_req ? byte_enable(r.size, r.addr[1:0]) : 4'b0000;
  assign mem_wdata = rep_wdata;
  assign resp_rd   = r.rd;

`ifdef MISALIGN_TRAP_EN
  logic fault_q;
  assign resp_fault = fault_q;
`else
  assign resp_fault = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      r          <= '0;
      mem_req    <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
`ifdef MISALIGN_TRAP_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            r <= '{is_store:    req_is_store,
                   size:        req_size,
                   is_unsigned: req_unsigned,
                   addr:        req_addr,
                   wdata:       req_wdata,
                   rd:          req_rd};
`ifdef MISALIGN_TRAP_EN
            fault_q <= 1'b0;
            if (misaligned(req_size, req_addr[1:0])) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= '0;
              fault_q    <= 1'b1;
            end else begin
              state   <= ISSUE;
              mem_req <= 1'b1;
            end
`else
            state   <= ISSUE;
            mem_req <= 1'b1;
`endif
          end
        end
        ISSUE: begin
          if (mem_ack) begin
            mem_req    <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= r.is_store ? '0 : load_data;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and random load/store transactions
// against a byte-arithmetic reference of the lane/extend rules.
module tb_mem_access_unit;
  import params_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic         req_is_store;
  access_size_t req_size;
  logic         req_unsigned;
  logic [31:0]  req_addr;
  logic [31:0]  req_wdata;
  logic [4:0]   req_rd;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [3:0]   mem_be;
  logic [31:0]  mem_wdata;
  logic         mem_ack;
  logic [31:0]  mem_rdata;
  logic         resp_valid;
  logic         resp_ready;
  logic [31:0]  resp_rdata;
  logic [4:0]   resp_rd;
  logic         resp_fault;

  int checks = 0;
  int errors = 0;

  mem_access_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_rd(resp_rd),
    .resp_fault(resp_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Reference: an access of n bytes covers bytes [aoff, aoff+n) of the
  // word, aoff being the offset rounded down to a multiple of n.
  function automatic void model(
    input  logic [1:0]  sz,
    input  logic [31:0] addr, wd, rdat,
    input  logic        uns,
    output bit          mis,
    output logic [3:0]  be,
    output logic [31:0] wexp, lexp, aexp
  );
    int n, off, aoff;
    logic [31:0] mask;
    n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off  = int'(addr[1:0]);
    mis  = (sz == 2'd3) || ((off % n) != 0);
    aoff = off - (off % n);
    be   = 4'(((1 << n) - 1) << aoff);
    for (int i = 0; i < 4; i++) wexp[8*i +: 8] = wd[8*(i % n) +: 8];
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
    lexp = (rdat >> (8 * aoff)) & mask;
    if (!uns && lexp[8*n-1]) lexp = lexp | ~mask;
    aexp = addr & ~32'h3;
  endfunction

  task automatic xact(
    input bit st, input logic [1:0] sz, input bit uns,
    input logic [31:0] addr, wd, input logic [4:0] rd,
    input int ackd, input logic [31:0] rdat,
    input int rdyd, input bit keepv
  );
    bit mis, trap;
    logic [3:0] be;
    logic [31:0] wexp, lexp, aexp, rexp;
    model(sz, addr, wd, rdat, uns, mis, be, wexp, lexp, aexp);
`ifdef MISALIGN_TRAP_EN
    trap = mis;
`else
    trap = 1'b0;
`endif
    rexp = (st || trap) ? 32'h0 : lexp;
    chk("idle_ready", req_ready, 1);
    req_valid    = 1'b1;
    req_is_store = st;
    req_size     = access_size_t'(sz);
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    req_rd       = rd;
    @(posedge clk); #1;
    if (!keepv) req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    if (trap) begin
      chk("trap_mem_req", mem_req, 0);
      chk("trap_resp_valid", resp_valid, 1);
      chk("trap_fault", resp_fault, 1);
      chk("trap_rdata", resp_rdata, 0);
    end else begin
      chk("issue_resp_valid", resp_valid, 0);
      chk("issue_req_ready", req_ready, 0);
      for (int i = 0; i <= ackd; i++) begin
        chk("issue_mem_req", mem_req, 1);
        chk("issue_mem_we", mem_we, st);
        chk("issue_mem_addr", mem_addr, aexp);
        chk("issue_mem_be", mem_be, be);
        if (st) chk("issue_mem_wdata", mem_wdata, wexp);
        if (i == ackd) begin
          mem_ack   = 1'b1;
          mem_rdata = rdat;
        end
        @(posedge clk); #1;
      end
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      chk("resp_mem_req", mem_req, 0);
      chk("resp_valid", resp_valid, 1);
      chk("resp_fault", resp_fault, 0);
      chk("resp_rdata", resp_rdata, rexp);
    end
    chk("resp_rd", resp_rd, rd);
    for (int i = 0; i < rdyd; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", resp_valid, 1);
      chk("hold_rdata", resp_rdata, rexp);
      chk("hold_mem_req", mem_req, 0);
      chk("hold_req_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    chk("done_valid", resp_valid, 0);
    chk("done_ready", req_ready, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_be"}, mem_be, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_rdata"}, resp_rdata, 0);
    chk({tag, "_resp_rd"}, resp_rd, 0);
    chk({tag, "_resp_fault"}, resp_fault, 0);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_is_store = 1'b0; req_size = SZ_WORD;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; req_rd = '0;
    mem_ack = 1'b0; mem_rdata = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_reset_vals("por");

    // Store word, ack after three ISSUE cycles.
    xact(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 5'd3, 2, 32'h0, 0, 1'b0);
    // Signed and unsigned byte load from lane 3.
    xact(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 5'd7, 0, 32'h80FF0000, 0, 1'b0);
    xact(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 5'd8, 1, 32'h80FF0000, 0, 1'b0);
    // Upper half store.
    xact(1'b1, 2'd1, 1'b0, 32'h102, 32'h1234ABCD, 5'd1, 0, 32'h0, 0, 1'b0);
    // Misaligned word load.
    xact(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 5'd9, 0, 32'hCAFEF00D, 0, 1'b0);
    // Response backpressure with req_valid left high.
    xact(1'b0, 2'd1, 1'b0, 32'h206, 32'h0, 5'd31, 1, 32'h8001_7FFF, 5, 1'b1);

    // Reset while ISSUE is waiting on memory.
    req_valid = 1'b1; req_is_store = 1'b1; req_size = SZ_WORD;
    req_addr = 32'h204; req_wdata = 32'h5555AAAA; req_rd = 5'd4;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("pre_rst_mem_req", mem_req, 1);
    #2 reset = 1'b1;
    #1;
    chk_reset_vals("async");
    @(posedge clk); #1 reset = 1'b0;
    mem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1 mem_ack = 1'b0;
    chk("late_ack_resp", resp_valid, 0);
    chk("late_ack_mem_req", mem_req, 0);
    chk("late_ack_ready", req_ready, 1);

    for (int k = 0; k < 60; k++) begin
      xact(1'($urandom), 2'($urandom), 1'($urandom), $urandom,
           $urandom, 5'($urandom), int'($urandom_range(0, 3)),
           $urandom, int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
